mmio_timer: RTL and testbench

MMIO_TIMER -- requirements
Module: mmio_timer

---
 rtl/mmio_timer.sv | 133 +++++++++++++
 tb/tb_mmio_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with 8-bit prescaler, reload/one-shot modes,
// zero and compare interrupt status (W1C) and a registered read port.
module mmio_timer #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic               pclk_i,
  input  logic               presetn_i,
  input  logic               wr_en_i,
  input  logic [A_WIDTH-1:0] wr_addr_i,
  input  logic [D_WIDTH-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [A_WIDTH-1:0] rd_addr_i,
  output logic [D_WIDTH-1:0] rd_data_o,
  output logic               irq_o
);

  localparam logic [2:0] R_CTRL  = 3'd0;
  localparam logic [2:0] R_LOAD  = 3'd1;
  localparam logic [2:0] R_COUNT = 3'd2;
  localparam logic [2:0] R_CMP   = 3'd3;
  localparam logic [2:0] R_IEN   = 3'd4;
  localparam logic [2:0] R_STS   = 3'd5;

  localparam logic [D_WIDTH-1:0] ONE = {{(D_WIDTH-1){1'b0}}, 1'b1};

  logic               ctrl_en, ctrl_reload;
  logic [7:0]         prescale, psc;
  logic [D_WIDTH-1:0] load, count, cmp;
  logic [1:0]         irq_en, irq_sts;

  logic [2:0]         widx, ridx;
  logic               wr_ctrl, wr_load, wr_cnt, wr_cmp, wr_ien, wr_sts;
  logic               tick, tick_eff, at_zero;
  logic               set_zero, set_cmp, oneshot_clr;
  logic [D_WIDTH-1:0] cnt_dec, rd_mux;
  logic [1:0]         sts_set, sts_clr;

  assign widx    = wr_addr_i[4:2];
  assign ridx    = rd_addr_i[4:2];
  assign wr_ctrl = wr_en_i && (widx == R_CTRL);
  assign wr_load = wr_en_i && (widx == R_LOAD);
  assign wr_cnt  = wr_en_i && (widx == R_COUNT);
  assign wr_cmp  = wr_en_i && (widx == R_CMP);
  assign wr_ien  = wr_en_i && (widx == R_IEN);
  assign wr_sts  = wr_en_i && (widx == R_STS);

  // A software COUNT write swallows a coincident tick entirely.
  assign tick        = ctrl_en && (psc == prescale);
  assign tick_eff    = tick && !wr_cnt;
  assign at_zero     = (count == '0);
  assign cnt_dec     = count - ONE;
  assign set_zero    = tick_eff && at_zero;
  assign set_cmp     = tick_eff && !at_zero && (cnt_dec == cmp);
  assign oneshot_clr = set_zero && !ctrl_reload;

  assign sts_set = {set_cmp, set_zero};
  assign sts_clr = wr_sts ? wr_data_i[1:0] : 2'b00;

  always_comb begin
    rd_mux = '0;
    case (ridx)
      R_CTRL: begin
        rd_mux[0]    = ctrl_en;
        rd_mux[1]    = ctrl_reload;
        rd_mux[15:8] = prescale;
      end
      R_LOAD:  rd_mux = load;
      R_COUNT: rd_mux = count;
      R_CMP:   rd_mux = cmp;
      R_IEN:   rd_mux[1:0] = irq_en;
      R_STS:   rd_mux[1:0] = irq_sts;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      ctrl_en     <= 1'b0;
      ctrl_reload <= 1'b0;
      prescale    <= '0;
      load        <= '0;
      cmp         <= '0;
      irq_en      <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= wr_data_i[0];
        ctrl_reload <= wr_data_i[1];
        prescale    <= wr_data_i[15:8];
      end
      // One-shot expiry overrides a simultaneous software enable.
      if (oneshot_clr) ctrl_en <= 1'b0;
      if (wr_load) load   <= wr_data_i;
      if (wr_cmp)  cmp    <= wr_data_i;
      if (wr_ien)  irq_en <= wr_data_i[1:0];
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      psc <= '0;
    end else if (wr_cnt || (wr_ctrl && !ctrl_en && wr_data_i[0])) begin
      psc <= '0;
    end else if (ctrl_en) begin
      psc <= tick ? 8'd0 : psc + 8'd1;
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      count <= '0;
    end else if (wr_cnt) begin
      count <= wr_data_i;
    end else if (tick_eff) begin
      if (!at_zero)         count <= cnt_dec;
      else if (ctrl_reload) count <= load;
    end
  end

  // Hardware set has priority over a W1C of the same bit.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) irq_sts <= '0;
    else            irq_sts <= (irq_sts & ~sts_clr) | sts_set;
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i)   rd_data_o <= '0;
    else if (rd_en_i) rd_data_o <= rd_mux;
  end

  assign irq_o = |(irq_sts & irq_en);

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed scenarios plus random register traffic, all
// checked against a cycle-level behavioural model of the timer's register map.
module tb_mmio_timer;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          pclk_i = 1'b0;
  logic          presetn_i = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [DW-1:0] wr_data_i = '0;
  logic          rd_en_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [DW-1:0] rd_data_o;
  logic          irq_o;

  int checks = 0;
  int errors = 0;

  mmio_timer #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .pclk_i(pclk_i), .presetn_i(presetn_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .irq_o(irq_o)
  );

  always #5 pclk_i = ~pclk_i;

  // Reference model state
  logic        m_en, m_rel;
  logic [7:0]  m_pre;
  int          m_psc;
  logic [31:0] m_load, m_count, m_cmp, m_rd;
  logic [1:0]  m_ien, m_sts;

  task automatic m_reset();
    m_en = 0; m_rel = 0; m_pre = 0; m_psc = 0;
    m_load = 0; m_count = 0; m_cmp = 0; m_rd = 0; m_ien = 0; m_sts = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    case (idx)
      3'd0: return {16'h0, m_pre, 6'h0, m_rel, m_en};
      3'd1: return m_load;
      3'd2: return m_count;
      3'd3: return m_cmp;
      3'd4: return {30'h0, m_ien};
      3'd5: return {30'h0, m_sts};
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock given the write on that clock.
  task automatic m_step(input logic we, input logic [2:0] idx, input logic [31:0] d);
    bit fires, cw, stop;
    logic [1:0] set;
    fires = m_en && (m_psc == int'(m_pre));
    cw = we && idx == 3'd2;
    stop = 0; set = 2'b00;
    if (m_en) m_psc = fires ? 0 : m_psc + 1;
    if (fires && !cw) begin
      if (m_count != 0) begin
        m_count = m_count - 1;
        if (m_count == m_cmp) set[1] = 1;
      end else begin
        set[0] = 1;
        if (m_rel) m_count = m_load;
        else       stop = 1;
      end
    end
    if (we) begin
      case (idx)
        3'd0: begin
          if (!m_en && d[0]) m_psc = 0;
          m_en = d[0]; m_rel = d[1]; m_pre = d[15:8];
        end
        3'd1: m_load = d;
        3'd2: begin m_count = d; m_psc = 0; end
        3'd3: m_cmp = d;
        3'd4: m_ien = d[1:0];
        3'd5: m_sts = m_sts & ~d[1:0];
        default: ;
      endcase
    end
    if (stop) m_en = 0;
    m_sts = m_sts | set;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the driven strobes, then outputs are compared.
  task automatic cyc();
    logic [31:0] nrd;
    nrd = rd_en_i ? m_read(rd_addr_i[4:2]) : m_rd;
    m_step(wr_en_i, wr_addr_i[4:2], wr_data_i);
    m_rd = nrd;
    @(posedge pclk_i); #1;
    wr_en_i = 0; rd_en_i = 0;
    chk("rd_data", rd_data_o, m_rd);
    chk("irq", {31'h0, irq_o}, {31'h0, |(m_sts & m_ien)});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en_i = 1; wr_addr_i = a; wr_data_i = d; cyc();
  endtask

  task automatic rd(input logic [31:0] a);
    rd_en_i = 1; rd_addr_i = a; cyc();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    #2 presetn_i = 0;
    m_reset();
    #1;
    chk("rst_rd_async", rd_data_o, 32'h0);
    chk("rst_irq_async", {31'h0, irq_o}, 32'h0);
    @(negedge pclk_i);
    presetn_i = 1;
    cyc();
  endtask

  int seq [6] = '{3, 2, 1, 0, 3, 2};

  initial begin
    m_reset();
    #1;
    chk("por_rd", rd_data_o, 32'h0);
    @(negedge pclk_i);
    presetn_i = 1;
    cyc();

    // Periodic reload
    wr(32'h04, 3); wr(32'h08, 3); wr(32'h10, 1); wr(32'h00, 3);
    for (int i = 0; i < 6; i++) begin
      rd(32'h08);
      chk("per_count", rd_data_o, seq[i]);
      if (i == 3) chk("per_irq", {31'h0, irq_o}, 32'h1);
    end
    wr(32'h14, 1);
    chk("per_w1c_irq", {31'h0, irq_o}, 32'h0);

    // Reset mid-count with irq pending
    idle(2);
    rd(32'h14);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rd(i * 4);
      chk("rst_reg", rd_data_o, 32'h0);
    end
    idle(3);
    rd(32'h08);
    chk("rst_idle_count", rd_data_o, 32'h0);

    // One-shot
    do_reset();
    wr(32'h08, 2); wr(32'h00, 1);
    idle(3);
    rd(32'h00);  chk("os_ctrl", rd_data_o, 32'h0);
    rd(32'h14);  chk("os_zero", rd_data_o & 32'h1, 32'h1);
    rd(32'h08);  chk("os_count", rd_data_o, 32'h0);

    // Prescale and freeze
    do_reset();
    wr(32'h08, 10); wr(32'h00, 32'h0401);
    for (int i = 1; i <= 12; i++) begin
      rd(32'h08);
      if (i == 5)  chk("psc_r5", rd_data_o, 10);
      if (i == 6)  chk("psc_r6", rd_data_o, 9);
      if (i == 11) chk("psc_r11", rd_data_o, 8);
    end
    wr(32'h00, 0);
    idle(4);
    rd(32'h08);  chk("psc_freeze", rd_data_o, 8);

    // Compare set vs W1C collision, COUNT write vs tick
    do_reset();
    wr(32'h0C, 5); wr(32'h08, 7); wr(32'h10, 2); wr(32'h00, 1);
    idle(1);
    wr(32'h14, 2);
    chk("cmp_irq", {31'h0, irq_o}, 32'h1);
    rd(32'h14);  chk("cmp_sts", rd_data_o, 32'h2);
    wr(32'h08, 100);
    rd(32'h08);  chk("cnt_wr_wins", rd_data_o, 100);
    rd(32'h08);  chk("cnt_after", rd_data_o, 99);

    // Read path, holes, aliasing, same-cycle read/write
    do_reset();
    wr(32'h04, 32'hA5A5);
    rd(32'h04);  chk("rd_load", rd_data_o, 32'hA5A5);
    idle(2);     chk("rd_hold", rd_data_o, 32'hA5A5);
    rd(32'h1C);  chk("rd_hole", rd_data_o, 32'h0);
    wr(32'h18, 32'hFFFF_FFFF);
    rd(32'h18);  chk("wr_hole", rd_data_o, 32'h0);
    wr(32'hFFFF_FF24, 32'h1234);
    rd(32'h04);  chk("alias", rd_data_o, 32'h1234);
    wr_en_i = 1; wr_addr_i = 32'h04; wr_data_i = 32'h77;
    rd_en_i = 1; rd_addr_i = 32'h04;
    cyc();       chk("rw_same", rd_data_o, 32'h1234);
    rd(32'h04);  chk("rw_after", rd_data_o, 32'h77);

    // Reload with LOAD=0 sets ZERO every tick
    do_reset();
    wr(32'h00, 3);
    wr(32'h14, 1);
    rd(32'h14);  chk("load0_zero", rd_data_o, 32'h1);

    // Random register traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] idx;
      logic [31:0] d;
      if ($urandom_range(0, 2) == 0) begin
        idx = 3'($urandom);
        case (idx)
          3'd0: begin d = $urandom; d[15:8] = 8'($urandom_range(0, 3)); end
          3'd1, 3'd2, 3'd3: d = $urandom_range(0, 12);
          default: d = $urandom;
        endcase
        wr_en_i = 1;
        wr_addr_i = ($urandom & ~32'h1C) | {27'h0, idx, 2'b00};
        wr_data_i = d;
      end
      if ($urandom_range(0, 1) == 0) begin
        rd_en_i = 1;
        rd_addr_i = $urandom;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
